// File: rtl/vga_fb_fetch_if.sv
// Read port between the framebuffer fetcher and the shared-RAM arbiter.
// One outstanding word read: req held with a stable address until ack returns data.
interface vga_fb_fetch_if #(
  parameter int unsigned ADDR_W = 21
) ();
  logic              ram_req;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ack;
  logic [31:0]       ram_data;

  modport master (
    output ram_req,
    output ram_addr,
    input  ram_ack,
    input  ram_data
  );

  modport slave (
    input  ram_req,
    input  ram_addr,
    output ram_ack,
    output ram_data
  );
endinterface

// File: rtl/vga_fb_fetch.sv
// Framebuffer pixel fetcher: prefetches packed RGB333 pixel pairs from RAM into a FIFO
// and hands one pixel per pix_req to the VGA timing stage, restarting on frame_start.
module vga_fb_fetch #(
  parameter int unsigned H_VISIBLE  = 800,
  parameter int unsigned V_VISIBLE  = 600,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 21
) (
  input  logic              clk50M,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ram_start_addr,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic [8:0]        pix_color,
  output logic              underflow,
  vga_fb_fetch_if.master    ram
);

  localparam int unsigned FRAME_WORDS = H_VISIBLE * V_VISIBLE / 2;
  localparam int unsigned WCNT_W      = $clog2(FRAME_WORDS + 1);
  localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W       = PTR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t            state;
  logic [17:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [WCNT_W-1:0] word_cnt;
  logic              phase;
  logic              active;

  logic              push_c;
  logic              pop_c;
  logic [CNT_W-1:0]  count_nxt_c;
  logic [WCNT_W-1:0] word_cnt_inc_c;
  logic              start_c;
  logic              stay_c;
  logic [17:0]       pair_c;
  logic              unused_data_c;

  // Only the two 9-bit pixel fields of each RAM word are kept.
  assign pair_c        = {ram.ram_data[24:16], ram.ram_data[8:0]};
  assign unused_data_c = ^{ram.ram_data[31:25], ram.ram_data[15:9]};

  always_comb begin
    push_c         = (state == REQ) && ram.ram_ack && !frame_start;
    pop_c          = pix_req && (count != '0) && phase && !frame_start;
    count_nxt_c    = count + CNT_W'(push_c) - CNT_W'(pop_c);
    word_cnt_inc_c = word_cnt + WCNT_W'(1);
    // A request is in flight while in REQ, so IDLE sees zero outstanding.
    start_c        = active && (word_cnt < WCNT_W'(FRAME_WORDS))
                     && (count < CNT_W'(FIFO_DEPTH));
    stay_c         = (word_cnt_inc_c < WCNT_W'(FRAME_WORDS))
                     && (count_nxt_c < CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk50M) begin
    if (push_c) begin
      mem[wr_ptr] <= pair_c;
    end
  end

  always_ff @(posedge clk50M) begin
    if (!rst_n) begin
      state        <= IDLE;
      ram.ram_req  <= 1'b0;
      ram.ram_addr <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      word_cnt     <= '0;
      phase        <= 1'b0;
      active       <= 1'b0;
      pix_color    <= '0;
      underflow    <= 1'b0;
    end else if (frame_start) begin
      // Abandons any in-flight request; a same-cycle ack is dropped.
      state        <= IDLE;
      ram.ram_req  <= 1'b0;
      ram.ram_addr <= ram_start_addr;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      word_cnt     <= '0;
      phase        <= 1'b0;
      active       <= 1'b1;
      pix_color    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_c) begin
            state       <= REQ;
            ram.ram_req <= 1'b1;
          end
        end
        REQ: begin
          if (ram.ram_ack) begin
            ram.ram_addr <= ram.ram_addr + ADDR_W'(1);
            word_cnt     <= word_cnt_inc_c;
            if (!stay_c) begin
              state       <= IDLE;
              ram.ram_req <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          ram.ram_req <= 1'b0;
        end
      endcase

      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      count <= count_nxt_c;

      // Low pixel of the head word first, then the high pixel pops the word.
      if (!pix_req) begin
        pix_color <= '0;
      end else if (count == '0) begin
        pix_color <= '0;
        underflow <= 1'b1;
      end else if (!phase) begin
        pix_color <= mem[rd_ptr][8:0];
        phase     <= 1'b1;
      end else begin
        pix_color <= mem[rd_ptr][17:9];
        phase     <= 1'b0;
        rd_ptr    <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_fetch.sv
// Bench for vga_fb_fetch: queue-based model of the pixel stream checked every cycle,
// plus directed scenarios with literal expectations.
module tb_vga_fb_fetch;

  localparam int unsigned H     = 16;
  localparam int unsigned V     = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 21;
  localparam int unsigned FW    = H * V / 2;

  logic          clk50M = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ram_start_addr = '0;
  logic          frame_start = 1'b0;
  logic          pix_req = 1'b0;
  logic [8:0]    pix_color;
  logic          underflow;

  int n_tests = 0;
  int n_fail  = 0;

  int   ack_mode = 0;      // 0 manual, 1 ack whenever requested, 2 random latency
  logic ack_man  = 1'b0;
  logic ack_rand = 1'b0;
  int   lat      = 0;

  vga_fb_fetch_if #(.ADDR_W(AW)) bus ();

  vga_fb_fetch #(
    .H_VISIBLE (H),
    .V_VISIBLE (V),
    .FIFO_DEPTH(DEPTH),
    .ADDR_W    (AW)
  ) dut (
    .clk50M        (clk50M),
    .rst_n         (rst_n),
    .ram_start_addr(ram_start_addr),
    .frame_start   (frame_start),
    .pix_req       (pix_req),
    .pix_color     (pix_color),
    .underflow     (underflow),
    .ram           (bus.master)
  );

  always #10 clk50M = ~clk50M;

  function automatic logic [8:0] pix_of(input logic [21:0] i);
    return 9'(i * 22'd37 + 22'd5);
  endfunction

  // RAM image: word a holds pixels 2a and 2a+1, with junk in the ignored bits.
  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    if (a == 21'h100) return 32'h01FF_0007;
    return {7'h2A, pix_of({a, 1'b1}), 7'h55, pix_of({a, 1'b0})};
  endfunction

  function automatic logic [8:0] img_pix(input logic [AW-1:0] start, input int n);
    logic [AW-1:0] a;
    logic [31:0]   w;
    a = start + AW'(n / 2);
    w = word_of(a);
    return (n % 2 == 1) ? w[24:16] : w[8:0];
  endfunction

  assign bus.ram_ack  = (ack_mode == 1) ? bus.ram_req :
                        (ack_mode == 2) ? ack_rand : ack_man;
  assign bus.ram_data = word_of(bus.ram_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk50M) begin
    if (ack_mode == 2) begin
      if (bus.ram_req && lat == 0) begin
        ack_rand = 1'b1;
        lat = $urandom_range(0, 3);
      end else begin
        ack_rand = 1'b0;
        if (bus.ram_req && lat > 0) lat--;
      end
    end else begin
      ack_rand = 1'b0;
    end
  end

  // ---------------- model ----------------
  logic [31:0]   q[$];
  bit            m_phase = 1'b0;
  bit            m_active = 1'b0;
  logic [8:0]    exp_color = '0;
  logic          exp_uf = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  int            frame_acks = 0;
  logic          s_req = 1'b0;
  logic [AW-1:0] s_addr = '0;
  bit            chk_en = 1'b0;

  always @(posedge clk50M) begin
    bit m_push;
    if (!rst_n) begin
      q.delete();
      m_phase = 1'b0; m_active = 1'b0;
      exp_color = '0; exp_uf = 1'b0; exp_addr = '0; frame_acks = 0;
    end else if (frame_start) begin
      q.delete();
      m_phase = 1'b0; m_active = 1'b1;
      exp_color = '0; exp_addr = ram_start_addr; frame_acks = 0;
    end else begin
      m_push = s_req && bus.ram_ack;
      if (m_push && chk_en) begin
        chk("ack_addr", 32'(s_addr), 32'(exp_addr));
        chk("push_not_full", 32'(q.size() < DEPTH), 32'd1);
        chk("acks_within_frame", 32'(frame_acks < FW), 32'd1);
      end
      if (!pix_req) begin
        exp_color = '0;
      end else if (q.size() == 0) begin
        exp_color = '0;
        exp_uf = 1'b1;
      end else if (!m_phase) begin
        exp_color = q[0][8:0];
        m_phase = 1'b1;
      end else begin
        exp_color = q[0][24:16];
        void'(q.pop_front());
        m_phase = 1'b0;
      end
      if (m_push) begin
        q.push_back(word_of(exp_addr));
        exp_addr = exp_addr + AW'(1);
        frame_acks++;
      end
    end
  end

  always @(negedge clk50M) begin
    s_req  = bus.ram_req;
    s_addr = bus.ram_addr;
    if (chk_en) begin
      chk("pix_color", 32'(pix_color), 32'(exp_color));
      chk("underflow", 32'(underflow), 32'(exp_uf));
      if (!m_active || frame_acks == int'(FW)) chk("req_quiet", 32'(bus.ram_req), 32'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk50M);
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.ram_req) break;
      tick();
    end
  endtask

  logic [8:0] got[$];

  initial begin
    int            n_req;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;

    tick(3);
    chk_en = 1'b1;
    chk("rst_pix_color", 32'(pix_color), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_ram_req", 32'(bus.ram_req), 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    rst_n = 1'b1;
    tick(5);
    chk("no_fetch_before_frame", 32'(bus.ram_req), 32'd0);

    // Fill: immediate acks stop after 16 words.
    ack_mode = 1;
    ram_start_addr = 21'h100;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_req = 0; first_addr = '0; last_addr = '0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.ram_req) begin
        if (n_req == 0) first_addr = bus.ram_addr;
        last_addr = bus.ram_addr;
        n_req++;
      end else if (n_req > 0) begin
        break;
      end
    end
    chk("fill_words", 32'(n_req), 32'd16);
    chk("fill_first_addr", 32'(first_addr), 32'h100);
    chk("fill_last_addr", 32'(last_addr), 32'h10F);
    tick(3);
    chk("fill_req_dropped", 32'(bus.ram_req), 32'd0);

    // Two pixels out of word 0x01FF_0007.
    pix_req = 1'b1;
    tick();
    chk("pix0", 32'(pix_color), 32'h007);
    tick();
    chk("pix1", 32'(pix_color), 32'h1FF);

    // Drain the rest of the frame.
    tick(62);
    pix_req = 1'b0;
    tick(2);
    chk("frame_acks", 32'(frame_acks), 32'(FW));
    chk("drain_no_underflow", 32'(underflow), 32'd0);
    tick(10);
    chk("frame_end_quiet", 32'(bus.ram_req), 32'd0);

    // frame_start with coincident pix_req and later with coincident ack.
    ack_mode = 0;
    ram_start_addr = 21'h200;
    pix_req = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    pix_req = 1'b0;
    chk("fs_pix_color", 32'(pix_color), 32'd0);
    chk("fs_no_underflow", 32'(underflow), 32'd0);
    wait_req(10);
    chk("req_at_new_start", 32'(bus.ram_req), 32'd1);
    chk("addr_at_new_start", 32'(bus.ram_addr), 32'h200);
    tick(2);
    ram_start_addr = 21'h300;
    frame_start = 1'b1;
    ack_man = 1'b1;
    tick();
    frame_start = 1'b0;
    ack_man = 1'b0;
    chk("fs_req_dropped", 32'(bus.ram_req), 32'd0);
    wait_req(10);
    chk("restart_addr", 32'(bus.ram_addr), 32'h300);
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
    chk("dropped_ack_empty_color", 32'(pix_color), 32'd0);
    chk("dropped_ack_underflow", 32'(underflow), 32'd1);

    // Sticky underflow after reset.
    rst_n = 1'b0;
    tick(2);
    chk("uf_cleared_by_reset", 32'(underflow), 32'd0);
    rst_n = 1'b1;
    tick();
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
    chk("empty_pix_color", 32'(pix_color), 32'd0);
    chk("empty_underflow", 32'(underflow), 32'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick(3);
    chk("uf_sticky_over_frame", 32'(underflow), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("uf_reset_again", 32'(underflow), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full frame with random ack latency and address wrap.
    ack_mode = 2;
    ram_start_addr = 21'h1F_FFF8;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick(30);
    got.delete();
    for (int line = 0; line < int'(V); line++) begin
      pix_req = 1'b1;
      for (int p = 0; p < int'(H); p++) begin
        tick();
        got.push_back(pix_color);
      end
      pix_req = 1'b0;
      tick(24);
    end
    chk("stream_no_underflow", 32'(underflow), 32'd0);
    chk("stream_len", 32'(got.size()), 32'(H * V));
    for (int n = 0; n < got.size(); n++) begin
      chk("stream_pix", 32'(got[n]), 32'(img_pix(21'h1F_FFF8, n)));
    end
    for (int i = 0; i < 200; i++) begin
      if (frame_acks == int'(FW)) break;
      tick();
    end
    chk("stream_frame_acks", 32'(frame_acks), 32'(FW));
    tick(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
